// File: rtl/simple_rx_pkg.sv
// Shared constants and types for the simple_rx packet receiver.
package simple_rx_pkg;

  // Register word index, i.e. byte offset >> 2 within the window.
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PKT_CNT  = 3'd1;
  localparam logic [2:0] REG_BYTE_CNT = 3'd2;
  localparam logic [2:0] REG_ERR_CNT  = 3'd3;
  localparam logic [2:0] REG_LAT_LAST = 3'd4;
  localparam logic [2:0] REG_LAT_MIN  = 3'd5;
  localparam logic [2:0] REG_LAT_MAX  = 3'd6;
  localparam logic [2:0] REG_TS_NOW   = 3'd7;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_ENABLE_BIT = 1;

  localparam logic [31:0] LAT_MIN_RST = 32'hFFFF_FFFF;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } rx_state_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/simple_rx_if.sv
// Bus bundles for simple_rx: AXI4-Lite register port and AXI-Stream packet port.
interface simple_rx_axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

interface simple_rx_axis_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/simple_rx_axil_regs.sv
// AXI4-Lite slave for simple_rx: handshakes, window decode, CTRL register and read mux.
module simple_rx_axil_regs
  import simple_rx_pkg::*;
#(
  parameter int                            C_S_AXI_DATA_WIDTH = 32,
  parameter int                            C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = 32'h0000_0000,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_HIGHADDR         = 32'h0000_001F
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  simple_rx_axil_if.slave       s_axil,
  input  logic [31:0]           pkt_cnt,
  input  logic [31:0]           byte_cnt,
  input  logic [31:0]           err_cnt,
  input  logic [31:0]           lat_last,
  input  logic [31:0]           lat_min,
  input  logic [31:0]           lat_max,
  input  logic [31:0]           ts_now_lo,
  output logic                  enable,
  output logic                  clear
);

  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] WIN_SPAN = C_HIGHADDR - C_BASEADDR;

  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_ofs;
  logic [C_S_AXI_ADDR_WIDTH-1:0] rd_ofs;
  logic                          wr_hit;
  logic                          rd_hit;
  logic [31:0]                   rd_mux;
  logic                          unused_axil;

  // Below-base addresses wrap to a large offset, so one compare covers both bounds.
  assign wr_ofs = s_axil.awaddr - C_BASEADDR;
  assign rd_ofs = s_axil.araddr - C_BASEADDR;
  assign wr_hit = (wr_ofs <= WIN_SPAN);
  assign rd_hit = (rd_ofs <= WIN_SPAN);

  assign unused_axil = ^{s_axil.wstrb, s_axil.wdata, wr_ofs, rd_ofs};

  always_comb begin
    rd_mux = '0;
    case (rd_ofs[4:2])
      REG_CTRL:     rd_mux[CTRL_ENABLE_BIT] = enable;
      REG_PKT_CNT:  rd_mux = pkt_cnt;
      REG_BYTE_CNT: rd_mux = byte_cnt;
      REG_ERR_CNT:  rd_mux = err_cnt;
      REG_LAT_LAST: rd_mux = lat_last;
      REG_LAT_MIN:  rd_mux = lat_min;
      REG_LAT_MAX:  rd_mux = lat_max;
      REG_TS_NOW:   rd_mux = ts_now_lo;
      default:      rd_mux = '0;
    endcase
    if (!rd_hit) rd_mux = '0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axil.awready <= 1'b0;
      s_axil.wready  <= 1'b0;
      s_axil.bvalid  <= 1'b0;
      s_axil.bresp   <= RESP_OKAY;
      s_axil.arready <= 1'b0;
      s_axil.rvalid  <= 1'b0;
      s_axil.rdata   <= '0;
      s_axil.rresp   <= RESP_OKAY;
      enable         <= 1'b1;
      clear          <= 1'b0;
    end else begin
      clear          <= 1'b0;
      s_axil.awready <= 1'b0;
      s_axil.wready  <= 1'b0;
      s_axil.arready <= 1'b0;

      if (s_axil.bvalid && s_axil.bready) s_axil.bvalid <= 1'b0;
      if (s_axil.awready && s_axil.awvalid && s_axil.wvalid) begin
        s_axil.bvalid <= 1'b1;
        s_axil.bresp  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
        if (wr_hit && wr_ofs[4:2] == REG_CTRL) begin
          enable <= s_axil.wdata[CTRL_ENABLE_BIT];
          clear  <= s_axil.wdata[CTRL_CLEAR_BIT];
        end
      end else if (!s_axil.bvalid && s_axil.awvalid && s_axil.wvalid) begin
        s_axil.awready <= 1'b1;
        s_axil.wready  <= 1'b1;
      end

      if (s_axil.rvalid && s_axil.rready) s_axil.rvalid <= 1'b0;
      if (s_axil.arready && s_axil.arvalid) begin
        s_axil.rvalid <= 1'b1;
        s_axil.rdata  <= C_S_AXI_DATA_WIDTH'(rd_mux);
        s_axil.rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (!s_axil.rvalid && s_axil.arvalid) begin
        s_axil.arready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/simple_rx.sv
// Loopback packet receiver: stream framing FSM, packet/byte/error counters and latency stats.
//   state   | meaning
//   IDLE    | waiting for beat 0 of a packet
//   BODY    | inside a packet, accumulating bytes
//   DROP    | packet interrupted by clear, discarding until TLAST
module simple_rx
  import simple_rx_pkg::*;
#(
  parameter int                            C_S_AXIS_DATA_WIDTH  = 256,
  parameter int                            C_S_AXIS_TUSER_WIDTH = 128,
  parameter int                            C_S_AXI_DATA_WIDTH   = 32,
  parameter int                            C_S_AXI_ADDR_WIDTH   = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR           = 32'h0000_0000,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_HIGHADDR           = 32'h0000_001F,
  parameter int                            C_TS_WIDTH           = 64
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  simple_rx_axil_if.slave  s_axil,
  simple_rx_axis_if.slave  s_axis,
  input  logic             ext_rst_count,
  output logic             rx_pkt_done,
  output logic             rx_err
);

  localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;

  rx_state_t             state;
  logic [C_TS_WIDTH-1:0] ts_now;
  logic [31:0]           pkt_bytes;
  logic [31:0]           lat_q;
  logic                  err_q;
  logic [31:0]           pkt_cnt;
  logic [31:0]           byte_cnt;
  logic [31:0]           err_cnt;
  logic [31:0]           lat_last;
  logic [31:0]           lat_min;
  logic [31:0]           lat_max;
  logic                  ctrl_enable;
  logic                  ctrl_clear;

  logic                  beat;
  logic                  clr;
  logic [31:0]           strb_pop;
  logic [STRB_W-1:0]     strb_p1;
  logic                  beat_bad;
  logic [C_TS_WIDTH-1:0] ts_diff;
  logic [31:0]           lat_now;
  logic                  fin_first;
  logic [31:0]           fin_bytes;
  logic                  fin_err;
  logic [31:0]           fin_lat;
  logic                  commit;
  logic                  unused_axis;

  assign beat = s_axis.tvalid & s_axis.tready;
  assign clr  = ctrl_clear | ext_rst_count;
  assign unused_axis = ^{s_axis.tuser, s_axis.tdata};

  always_comb begin
    strb_pop = '0;
    for (int i = 0; i < STRB_W; i++) strb_pop = strb_pop + 32'(s_axis.tstrb[i]);
  end

  // A strobe of the form 0..01..1 has no overlap with itself plus one.
  assign strb_p1  = s_axis.tstrb + STRB_W'(1);
  assign beat_bad = (s_axis.tstrb == '0)
                 || ((s_axis.tstrb & strb_p1) != '0)
                 || (!s_axis.tlast && (s_axis.tstrb != '1));

  assign ts_diff = ts_now - s_axis.tdata[C_TS_WIDTH-1:0];
  assign lat_now = (ts_diff > C_TS_WIDTH'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : ts_diff[31:0];

  assign fin_first = (state == ST_IDLE);
  assign fin_bytes = fin_first ? strb_pop : sat_add32(pkt_bytes, strb_pop);
  assign fin_err   = beat_bad | (!fin_first & err_q);
  assign fin_lat   = fin_first ? lat_now : lat_q;
  assign commit    = beat & s_axis.tlast & (state != ST_DROP) & !clr;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) ts_now <= '0;
    else                ts_now <= ts_now + C_TS_WIDTH'(1);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state         <= ST_IDLE;
      pkt_bytes     <= '0;
      lat_q         <= '0;
      err_q         <= 1'b0;
      pkt_cnt       <= '0;
      byte_cnt      <= '0;
      err_cnt       <= '0;
      lat_last      <= '0;
      lat_min       <= LAT_MIN_RST;
      lat_max       <= '0;
      rx_pkt_done   <= 1'b0;
      rx_err        <= 1'b0;
      s_axis.tready <= 1'b0;
    end else begin
      s_axis.tready <= ctrl_enable;
      rx_pkt_done   <= commit;
      rx_err        <= commit & fin_err;

      if (beat) begin
        pkt_bytes <= fin_bytes;
        err_q     <= fin_err;
        if (fin_first) lat_q <= lat_now;
      end

      case (state)
        ST_IDLE: if (beat && !s_axis.tlast) state <= clr ? ST_DROP : ST_BODY;
        ST_BODY: begin
          if (beat && s_axis.tlast) state <= ST_IDLE;
          else if (clr)             state <= ST_DROP;
        end
        ST_DROP: if (beat && s_axis.tlast) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // Clear beats a same-cycle commit: that packet is simply lost.
      if (clr) begin
        pkt_cnt  <= '0;
        byte_cnt <= '0;
        err_cnt  <= '0;
        lat_last <= '0;
        lat_min  <= LAT_MIN_RST;
        lat_max  <= '0;
      end else if (commit) begin
        pkt_cnt  <= sat_add32(pkt_cnt, 32'd1);
        byte_cnt <= sat_add32(byte_cnt, fin_bytes);
        if (fin_err) begin
          err_cnt <= sat_add32(err_cnt, 32'd1);
        end else begin
          lat_last <= fin_lat;
          if (fin_lat < lat_min) lat_min <= fin_lat;
          if (fin_lat > lat_max) lat_max <= fin_lat;
        end
      end
    end
  end

  simple_rx_axil_regs #(
    .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
    .C_BASEADDR         (C_BASEADDR),
    .C_HIGHADDR         (C_HIGHADDR)
  ) u_regs (
    .aclk      (S_AXI_ACLK),
    .aresetn   (S_AXI_ARESETN),
    .s_axil    (s_axil),
    .pkt_cnt   (pkt_cnt),
    .byte_cnt  (byte_cnt),
    .err_cnt   (err_cnt),
    .lat_last  (lat_last),
    .lat_min   (lat_min),
    .lat_max   (lat_max),
    .ts_now_lo (ts_now[31:0]),
    .enable    (ctrl_enable),
    .clear     (ctrl_clear)
  );

endmodule
